fetch_unit: RTL

//   Instruction-fetch stage: owns the PC, requests one 32-bit word per instruction

---
 rtl/fetch_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC, single-outstanding imem fetch, valid/ready toward decode
// Optional MISALIGN_TRAP_EN: a misaligned next PC traps (TRAP state, misalign=1) instead of being force-aligned.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm,
    input  logic [31:0] jalr_base,
    output logic        misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
`ifdef MISALIGN_TRAP_EN
    localparam logic [1:0] S_TRAP = 2'd3;
`endif

    logic [1:0]  state;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    always_comb begin
        next_pc_raw = pc_plus4;
        case (pc_src)
            2'b01:   next_pc_raw = pc + imm;
            2'b10:   next_pc_raw = (jalr_base + imm) & ~32'd1;
            default: next_pc_raw = pc_plus4;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign next_pc = next_pc_raw;
`else
    // Without the trap, low bits are simply dropped so fetches stay word-aligned.
    assign next_pc = next_pc_raw & ~32'd3;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
`ifdef MISALIGN_TRAP_EN
                        if (next_pc[1:0] != 2'b00) state <= S_TRAP;
                        else                       state <= S_REQ;
`else
                        state       <= S_REQ;
`endif
                    end
                end
`ifdef MISALIGN_TRAP_EN
                S_TRAP: state <= S_TRAP;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign <= 1'b0;
        end else if (state == S_HOLD && instr_ready && next_pc[1:0] != 2'b00) begin
            misalign <= 1'b1;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
